write_resp_channel_arb: RTL and testbench

//  Return path of the AXI write-response (B) channel in the interconnect. Collects B responses

---
 rtl/write_resp_channel_arb.sv | 121 ++++++++++++
 tb/tb_write_resp_channel_arb.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/write_resp_channel_arb.sv
// write_resp_channel_arb
// Return path of the write-response (B) channel. Two slave ports offer responses.
// A round-robin pointer picks the winner, which is captured into a one-deep holding
// register. The held response is then delivered to the master named by its ID.
// Only one response is in flight at a time.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   S0x_AXI_bid/bresp/bvalid      slave response in (bid = target master)
//   S0x_AXI_bready                capture strobe to slave (combinational, IDLE only)
//   M0x_AXI_bresp/bvalid          response to master (driven from flops)
//   M0x_AXI_bready                master accepts response
//   Resp_Busy                     a response is being held
//   Err_Count                     saturating count of SLVERR/DECERR/undeliverable responses
module write_resp_channel_arb #(
  parameter int unsigned Num_OF_Masters  = 2,
  parameter int unsigned Masters_ID_Size = (Num_OF_Masters > 1) ? $clog2(Num_OF_Masters) : 1,
  parameter int unsigned Err_Cnt_Width   = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [Masters_ID_Size-1:0] S00_AXI_bid,
  input  logic [1:0]                 S00_AXI_bresp,
  input  logic                       S00_AXI_bvalid,
  output logic                       S00_AXI_bready,
  input  logic [Masters_ID_Size-1:0] S01_AXI_bid,
  input  logic [1:0]                 S01_AXI_bresp,
  input  logic                       S01_AXI_bvalid,
  output logic                       S01_AXI_bready,
  output logic [1:0]                 M00_AXI_bresp,
  output logic                       M00_AXI_bvalid,
  input  logic                       M00_AXI_bready,
  output logic [1:0]                 M01_AXI_bresp,
  output logic                       M01_AXI_bvalid,
  input  logic                       M01_AXI_bready,
  output logic                       Resp_Busy,
  output logic [Err_Cnt_Width-1:0]   Err_Count
);

  typedef enum logic [0:0] {StIdle, StHold} state_e;

  state_e                   state_q;
  logic                     ptr_q;       // 0: S00 has priority, 1: S01 has priority
  logic                     served_q;    // slave whose response is held
  logic                     held_err_q;  // held response counts as an error on release
  logic                     m0_valid_q, m1_valid_q;
  logic [1:0]               m0_resp_q, m1_resp_q;
  logic [Err_Cnt_Width-1:0] err_q;

  logic                       grant_s0, grant_s1;
  logic [Masters_ID_Size-1:0] win_id;
  logic [1:0]                 win_resp;
  logic                       win_to_m0, win_to_m1;
  logic                       release_hold;

  always_comb begin
    grant_s0 = !rst && (state_q == StIdle) && S00_AXI_bvalid && (!ptr_q || !S01_AXI_bvalid);
    grant_s1 = !rst && (state_q == StIdle) && S01_AXI_bvalid && (ptr_q || !S00_AXI_bvalid);
    win_id   = grant_s1 ? S01_AXI_bid   : S00_AXI_bid;
    win_resp = grant_s1 ? S01_AXI_bresp : S00_AXI_bresp;
    // An ID without a master port decodes to neither output.
    win_to_m0 = (32'(win_id) == 32'd0) && (Num_OF_Masters > 0);
    win_to_m1 = (32'(win_id) == 32'd1) && (Num_OF_Masters > 1);
    // With no master addressed the response is simply dropped after one HOLD cycle.
    release_hold = !(m0_valid_q || m1_valid_q)
                 || (m0_valid_q && M00_AXI_bready)
                 || (m1_valid_q && M01_AXI_bready);
  end

  assign S00_AXI_bready = grant_s0;
  assign S01_AXI_bready = grant_s1;
  assign M00_AXI_bvalid = m0_valid_q;
  assign M00_AXI_bresp  = m0_resp_q;
  assign M01_AXI_bvalid = m1_valid_q;
  assign M01_AXI_bresp  = m1_resp_q;
  assign Resp_Busy      = (state_q == StHold);
  assign Err_Count      = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      ptr_q      <= 1'b0;
      served_q   <= 1'b0;
      held_err_q <= 1'b0;
      m0_valid_q <= 1'b0;
      m1_valid_q <= 1'b0;
      m0_resp_q  <= 2'b00;
      m1_resp_q  <= 2'b00;
      err_q      <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (grant_s0 || grant_s1) begin
            state_q    <= StHold;
            served_q   <= grant_s1;
            held_err_q <= win_resp[1] || !(win_to_m0 || win_to_m1);
            m0_valid_q <= win_to_m0;
            m1_valid_q <= win_to_m1;
            m0_resp_q  <= win_to_m0 ? win_resp : 2'b00;
            m1_resp_q  <= win_to_m1 ? win_resp : 2'b00;
          end
        end
        StHold: begin
          if (release_hold) begin
            state_q    <= StIdle;
            ptr_q      <= ~served_q;
            m0_valid_q <= 1'b0;
            m1_valid_q <= 1'b0;
            m0_resp_q  <= 2'b00;
            m1_resp_q  <= 2'b00;
            if (held_err_q && (err_q != '1)) begin
              err_q <= err_q + 1'b1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_write_resp_channel_arb.sv
module tb_write_resp_channel_arb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       s0_bid, s1_bid;
  logic [1:0] s0_bresp, s1_bresp;
  logic       s0_bvalid, s1_bvalid;
  logic       s0_bready, s1_bready, s0_bready2, s1_bready2;
  logic [1:0] m0_bresp, m1_bresp, m0_bresp2, m1_bresp2;
  logic       m0_bvalid, m1_bvalid, m0_bvalid2, m1_bvalid2;
  logic       m0_bready, m1_bready;
  logic       busy, busy2;
  logic [7:0] err;
  logic [1:0] err2;

  write_resp_channel_arb dut (
    .clk(clk), .rst(rst),
    .S00_AXI_bid(s0_bid), .S00_AXI_bresp(s0_bresp), .S00_AXI_bvalid(s0_bvalid),
    .S00_AXI_bready(s0_bready),
    .S01_AXI_bid(s1_bid), .S01_AXI_bresp(s1_bresp), .S01_AXI_bvalid(s1_bvalid),
    .S01_AXI_bready(s1_bready),
    .M00_AXI_bresp(m0_bresp), .M00_AXI_bvalid(m0_bvalid), .M00_AXI_bready(m0_bready),
    .M01_AXI_bresp(m1_bresp), .M01_AXI_bvalid(m1_bvalid), .M01_AXI_bready(m1_bready),
    .Resp_Busy(busy), .Err_Count(err)
  );

  // Narrow error counter to exercise saturation.
  write_resp_channel_arb #(.Err_Cnt_Width(2)) dut2 (
    .clk(clk), .rst(rst),
    .S00_AXI_bid(s0_bid), .S00_AXI_bresp(s0_bresp), .S00_AXI_bvalid(s0_bvalid),
    .S00_AXI_bready(s0_bready2),
    .S01_AXI_bid(s1_bid), .S01_AXI_bresp(s1_bresp), .S01_AXI_bvalid(s1_bvalid),
    .S01_AXI_bready(s1_bready2),
    .M00_AXI_bresp(m0_bresp2), .M00_AXI_bvalid(m0_bvalid2), .M00_AXI_bready(m0_bready),
    .M01_AXI_bresp(m1_bresp2), .M01_AXI_bvalid(m1_bvalid2), .M01_AXI_bready(m1_bready),
    .Resp_Busy(busy2), .Err_Count(err2)
  );

  int unsigned n_checks = 0;
  int unsigned n_errs   = 0;

  // Reference: at most one response in flight, plus the priority slave and error total.
  bit         known = 0;
  bit         in_flight = 0;
  int         flight_id = 0;
  logic [1:0] flight_resp = 2'b00;
  int         flight_src = 0;
  int         prio = 0;
  int         errs_seen = 0;
  int         taken = -1;  // slave accepted in the last cycle, -1 if none

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_s(input int s, input bit v, input bit id, input logic [1:0] r);
    if (s == 0) begin
      s0_bvalid = v; s0_bid = id; s0_bresp = r;
    end else begin
      s1_bvalid = v; s1_bid = id; s1_bresp = r;
    end
  endtask

  // One clock: check the settled outputs against the reference, then advance it.
  task automatic tick();
    int         win;
    int         other;
    bit         ok0, ok1;
    logic [1:0] r0, r1;
    #1;
    taken = -1;
    if (rst) begin
      chk("rst_s0_bready", s0_bready, 0);
      chk("rst_s1_bready", s1_bready, 0);
      known     = 1;
      in_flight = 0;
      prio      = 0;
      errs_seen = 0;
    end else begin
      win   = -1;
      other = 1 - prio;
      ok0   = s0_bvalid;
      ok1   = s1_bvalid;
      if (!in_flight) begin
        if ((prio == 0 && ok0) || (prio == 1 && ok1)) win = prio;
        else if ((other == 0 && ok0) || (other == 1 && ok1)) win = other;
      end
      chk("s0_bready", s0_bready, (win == 0));
      chk("s1_bready", s1_bready, (win == 1));
      if (known) begin
        r0 = (in_flight && flight_id == 0) ? flight_resp : 2'b00;
        r1 = (in_flight && flight_id == 1) ? flight_resp : 2'b00;
        chk("busy", busy, in_flight);
        chk("m0_bvalid", m0_bvalid, (in_flight && flight_id == 0));
        chk("m1_bvalid", m1_bvalid, (in_flight && flight_id == 1));
        chk("m0_bresp", m0_bresp, r0);
        chk("m1_bresp", m1_bresp, r1);
        chk("err_count", err, (errs_seen > 255) ? 255 : errs_seen);
        chk("err_count_w2", err2, (errs_seen > 3) ? 3 : errs_seen);
      end
      if (win >= 0) begin
        in_flight   = 1;
        flight_src  = win;
        flight_id   = (win == 0) ? int'(s0_bid) : int'(s1_bid);
        flight_resp = (win == 0) ? s0_bresp : s1_bresp;
        taken       = win;
      end else if (in_flight && ((flight_id == 0 && m0_bready) || (flight_id == 1 && m1_bready))) begin
        in_flight = 0;
        prio      = 1 - flight_src;
        if (flight_resp[1]) errs_seen++;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    m0_bready = 1'b0;
    m1_bready = 1'b0;
    @(negedge clk);

    // Reset with both slaves requesting: nothing accepted; S00 wins afterwards.
    set_s(0, 1, 0, 2'b00);
    set_s(1, 1, 1, 2'b00);
    tick();
    tick();
    rst = 1'b0;
    #1 chk("t1_s00_first", s0_bready, 1);
    tick();
    set_s(0, 0, 0, 2'b00);
    m0_bready = 1'b1;
    m1_bready = 1'b1;
    #1 chk("t3_m00_first", m0_bvalid, 1);
    tick();
    #1 chk("t3_s01_second", s1_bready, 1);
    tick();
    set_s(1, 0, 0, 2'b00);
    #1 chk("t3_m01_second", m1_bvalid, 1);
    tick();

    // Single request from S01 to M01.
    set_s(1, 1, 1, 2'b00);
    tick();
    set_s(1, 0, 0, 2'b00);
    #1 chk("t2_m00_idle", m0_bvalid, 0);
    tick();

    // SLVERR held while M00 stalls; M01 bready must not release it.
    m0_bready = 1'b0;
    m1_bready = 1'b1;
    set_s(0, 1, 0, 2'b10);
    tick();
    set_s(0, 0, 0, 2'b00);
    for (int i = 0; i < 5; i++) begin
      #1 chk("t4_stable_resp", {m0_bvalid, m0_bresp}, 3'b110);
      tick();
    end
    m0_bready = 1'b1;
    tick();
    #1 chk("t4_err_one", err, 1);
    tick();

    // Four DECERR responses: narrow counter saturates.
    for (int i = 0; i < 4; i++) begin
      set_s(1, 1, 1, 2'b11);
      tick();
      set_s(1, 0, 0, 2'b00);
      tick();
    end
    #1 chk("t5_sat", err2, 3);

    // Reset while holding drops the response.
    m0_bready = 1'b0;
    set_s(0, 1, 0, 2'b01);
    tick();
    set_s(0, 0, 0, 2'b00);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1 chk("t6_dropped", {m0_bvalid, busy}, 2'b00);
    tick();

    // Randomized traffic obeying the slave-side valid/hold rule.
    for (int c = 0; c < 3000; c++) begin
      if (taken == 0 || !s0_bvalid) begin
        if ($urandom_range(0, 1) == 1)
          set_s(0, 1, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
        else
          set_s(0, 0, 0, 2'b00);
      end
      if (taken == 1 || !s1_bvalid) begin
        if ($urandom_range(0, 1) == 1)
          set_s(1, 1, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
        else
          set_s(1, 0, 0, 2'b00);
      end
      m0_bready = 1'($urandom_range(0, 1));
      m1_bready = 1'($urandom_range(0, 1));
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
